// File: rtl/store_pkg.sv
// Shared types for the store narrowing unit:
// size codes, FSM states and the latched request bundle.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    RWAIT = 2'd2,
    WR    = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0]  off;
    size_e       size;
    logic [31:0] data;
  } req_t;

endpackage

// File: rtl/lane_merge.sv
// Little-endian lane merge: drops the low byte/half of new_data into
// old_word at the lane picked by off; word (and 11) pass new_data.
module lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  size_e       size,
  input  logic [1:0]  off,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    unique case (1'b1)
      size == SZ_BYTE:
        merged[{off, 3'b000} +: 8] = new_data[7:0];
      size == SZ_HALF:
        merged[{off[1], 4'b0000} +: 16] = new_data[15:0];
      default:
        merged = new_data;
    endcase
  end

endmodule

// File: rtl/store_narrow_rmw.sv
// Store narrowing unit: word stores write directly, byte/half stores
// do read-modify-write. Define STORE_MISALIGN_TRAP_EN to reject
// misaligned half/word and reserved-size requests (done+err, no access).
// Ports: Clk/Clrn, req_* handshake, done/err, mem_* command/response.
module store_narrow_rmw
  import store_pkg::*;
(
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        done,
  output logic        err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  state_e      state;
  state_e      state_n;
  req_t        req_q;
  size_e       req_sz;
  logic        accept;
  logic        reject;
  logic        sub_word;
  logic [31:0] merged;

  assign req_sz    = size_e'(req_size);
  assign req_ready = (state == IDLE);
  assign accept    = req_ready && req_valid;
  assign sub_word  = (req_sz == SZ_BYTE) ||
                     (req_sz == SZ_HALF);

`ifdef STORE_MISALIGN_TRAP_EN
  assign reject =
    (req_sz == SZ_HALF && req_addr[0]) ||
    (req_sz == SZ_WORD && req_addr[1:0] != 2'b00) ||
    (req_sz == SZ_RSVD);
`else
  assign reject = 1'b0;
`endif

  lane_merge u_merge (
    .old_word (mem_rdata),
    .new_data (req_q.data),
    .size     (req_q.size),
    .off      (req_q.off),
    .merged   (merged)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (accept && !reject)
          state_n = sub_word ? RD : WR;
      RD:
        if (mem_ready) state_n = RWAIT;
      RWAIT:
        if (mem_rvalid) state_n = WR;
      WR:
        if (mem_ready) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) state <= IDLE;
    else       state <= state_n;
  end

  // Command outputs are registered from the next state so they are
  // stable for the whole time a command is held by back-pressure.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      req_q     <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_valid <= (state_n == RD) || (state_n == WR);
      mem_we    <= (state_n == WR);
      done      <= (state == WR && mem_ready) ||
                   (accept && reject);
      err       <= accept && reject;
      if (accept) begin
        req_q     <= '{off: req_addr[1:0],
                       size: req_sz,
                       data: req_data};
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wdata <= req_data;
      end
      if (state == RWAIT && mem_rvalid)
        mem_wdata <= merged;
    end
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Directed bench for store_narrow_rmw with a small memory responder
// (programmable stall, read data one cycle after read accept).
module tb_store_narrow_rmw;

  logic        Clk = 1'b0;
  logic        Clrn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        done;
  logic        err;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 Clk = ~Clk;

  store_narrow_rmw dut (
    .Clk        (Clk),
    .Clrn       (Clrn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_size   (req_size),
    .done       (done),
    .err        (err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] mem_word = '0;
  int          stall_cfg = 0;
  int          stall_left = 0;
  bit          rd_pend = 0;
  bit          rv_hold = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] rd_addr = '0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  bit          held = 0;
  logic [31:0] h_addr = '0;
  logic [31:0] h_wdata = '0;
  logic        h_we = 1'b0;

  always @(negedge Clk) begin
    if (rd_pend && !rv_hold) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word;
      rd_pend    = 0;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    mem_ready = 1'b0;
    if (mem_valid) begin
      if (held) begin
        check("hold_addr", mem_addr, h_addr);
        check("hold_we", 32'(mem_we), 32'(h_we));
        check("hold_wdata", mem_wdata, h_wdata);
      end
      if (stall_left > 0) begin
        stall_left--;
        held    = 1;
        h_addr  = mem_addr;
        h_we    = mem_we;
        h_wdata = mem_wdata;
      end else begin
        mem_ready  = 1'b1;
        held       = 0;
        stall_left = stall_cfg;
        if (mem_we) begin
          wr_cnt++;
          wr_addr = mem_addr;
          wr_data = mem_wdata;
        end else begin
          rd_cnt++;
          rd_addr = mem_addr;
          rd_pend = 1;
        end
      end
    end
  end

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [1:0]  sz,
                       output int         lat,
                       output logic       e);
    @(negedge Clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = sz;
    lat = -1;
    e   = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      req_valid = 1'b0;
      if (done) begin
        lat = k;
        e   = err;
        check("ready_at_done", 32'(req_ready), 32'd1);
        break;
      end
    end
    #1;
  endtask

  int   lat;
  logic e;
  int   r0;
  int   w0;
  bit   any_valid;

  initial begin
    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    @(negedge Clk);
    Clrn = 1'b1;

    r0 = rd_cnt; w0 = wr_cnt;
    store(32'h100, 32'hDEADBEEF, 2'b10, lat, e);
    check("w_lat", 32'(lat), 32'd2);
    check("w_err", 32'(e), 32'd0);
    check("w_nrd", 32'(rd_cnt - r0), 32'd0);
    check("w_nwr", 32'(wr_cnt - w0), 32'd1);
    check("w_addr", wr_addr, 32'h100);
    check("w_data", wr_data, 32'hDEADBEEF);

    mem_word = 32'h11223344;
    r0 = rd_cnt; w0 = wr_cnt;
    store(32'h203, 32'h123456AB, 2'b00, lat, e);
    check("b_lat", 32'(lat), 32'd4);
    check("b_nrd", 32'(rd_cnt - r0), 32'd1);
    check("b_raddr", rd_addr, 32'h200);
    check("b_waddr", wr_addr, 32'h200);
    check("b_data", wr_data, 32'hAB223344);

    mem_word = 32'h55667788;
    store(32'h302, 32'hFFFFCAFE, 2'b01, lat, e);
    check("h_lat", 32'(lat), 32'd4);
    check("h_waddr", wr_addr, 32'h300);
    check("h_data", wr_data, 32'hCAFE7788);

    mem_word   = 32'h11223344;
    stall_cfg  = 3;
    stall_left = 3;
    r0 = rd_cnt; w0 = wr_cnt;
    store(32'h201, 32'h0000005A, 2'b00, lat, e);
    stall_cfg  = 0;
    stall_left = 0;
    check("bp_lat", 32'(lat), 32'd10);
    check("bp_nwr", 32'(wr_cnt - w0), 32'd1);
    check("bp_data", wr_data, 32'h11225A44);

    mem_word = 32'hAABBCCDD;
    r0 = rd_cnt; w0 = wr_cnt;
    store(32'h401, 32'h0000BEEF, 2'b01, lat, e);
`ifdef STORE_MISALIGN_TRAP_EN
    check("mis_lat", 32'(lat), 32'd1);
    check("mis_err", 32'(e), 32'd1);
    check("mis_nrd", 32'(rd_cnt - r0), 32'd0);
    check("mis_nwr", 32'(wr_cnt - w0), 32'd0);
`else
    check("mis_lat", 32'(lat), 32'd4);
    check("mis_err", 32'(e), 32'd0);
    check("mis_raddr", rd_addr, 32'h400);
    check("mis_data", wr_data, 32'hAABBBEEF);
`endif

    r0 = rd_cnt; w0 = wr_cnt;
    store(32'h502, 32'h13579BDF, 2'b11, lat, e);
`ifdef STORE_MISALIGN_TRAP_EN
    check("rsv_lat", 32'(lat), 32'd1);
    check("rsv_err", 32'(e), 32'd1);
    check("rsv_nwr", 32'(wr_cnt - w0), 32'd0);
`else
    check("rsv_lat", 32'(lat), 32'd2);
    check("rsv_nrd", 32'(rd_cnt - r0), 32'd0);
    check("rsv_addr", wr_addr, 32'h500);
    check("rsv_data", wr_data, 32'h13579BDF);
`endif

    rv_hold = 1;
    mem_word = 32'h0;
    r0 = rd_cnt; w0 = wr_cnt;
    @(negedge Clk);
    req_valid = 1'b1;
    req_addr  = 32'h600;
    req_data  = 32'h77;
    req_size  = 2'b00;
    @(negedge Clk);
    req_valid = 1'b0;
    @(negedge Clk);
    check("rw_valid", 32'(mem_valid), 32'd0);
    #2 Clrn = 1'b0;
    #1;
    check("mr_valid", 32'(mem_valid), 32'd0);
    check("mr_ready", 32'(req_ready), 32'd1);
    check("mr_done", 32'(done), 32'd0);
    @(negedge Clk);
    Clrn    = 1'b1;
    rv_hold = 0;
    any_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (mem_valid || done) any_valid = 1;
    end
    #1;
    check("mr_nrd", 32'(rd_cnt - r0), 32'd1);
    check("mr_nwr", 32'(wr_cnt - w0), 32'd0);
    check("mr_quiet", 32'(any_valid), 32'd0);
    check("mr_idle", 32'(req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
